debug_cmd_sequencer: RTL and testbench

- Sysclk-domain sequencer between the debug slave's decoded JTAG commands (ir code plus 38-bit jdo word) and the on-chip debug memory and break registers.
- Serialises one command at a time and drives the debug-memory request/acknowledge handshake, with auto-increment addressing and a timeout guard.
- Returns read data and completion status to the JTAG capture path, in place of ad-hoc take_action pulses.

---
 rtl/debug_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_debug_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_sequencer.sv
// Serialises decoded JTAG debug commands onto the debug-memory req/ack handshake and the
// break-register write port, returning read data and completion status to the capture path.
module debug_cmd_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter bit          AUTOINC = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd_ir,
  input  logic [37:0]       i_cmd_jdo,
  output logic              o_cmd_ready,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_brk_we,
  output logic [1:0]        o_brk_sel,
  output logic [31:0]       o_brk_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_data,
  output logic              o_monitor_ready,
  output logic              o_monitor_error,
  output logic              o_overrun
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  localparam logic [1:0] OpSetAddr = 2'b01;
  localparam logic [1:0] OpWrite   = 2'b10;
  localparam logic [1:0] OpRead    = 2'b11;

  typedef enum logic [1:0] {StIdle, StMemReq, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [1:0]        r_brk_sel, w_brk_sel_d;
  logic [31:0]       r_data, w_data_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [31:0]       r_rsp_data, w_rsp_data_d;
  logic              r_mon_ready, w_mon_ready_d;
  logic              r_mon_error, w_mon_error_d;
  logic              r_overrun, w_overrun_d;
  logic              r_brk_we, w_brk_we_d;

  // jdo[35] carries no meaning for this block
  logic w_unused_jdo;
  assign w_unused_jdo = i_cmd_jdo[35];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_op        <= '0;
      r_brk_sel   <= '0;
      r_data      <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_mon_ready <= 1'b0;
      r_mon_error <= 1'b0;
      r_overrun   <= 1'b0;
      r_brk_we    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_op        <= w_op_d;
      r_brk_sel   <= w_brk_sel_d;
      r_data      <= w_data_d;
      r_addr      <= w_addr_d;
      r_cnt       <= w_cnt_d;
      r_rsp_data  <= w_rsp_data_d;
      r_mon_ready <= w_mon_ready_d;
      r_mon_error <= w_mon_error_d;
      r_overrun   <= w_overrun_d;
      r_brk_we    <= w_brk_we_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_op_d        = r_op;
    w_brk_sel_d   = r_brk_sel;
    w_data_d      = r_data;
    w_addr_d      = r_addr;
    w_cnt_d       = r_cnt;
    w_rsp_data_d  = r_rsp_data;
    w_mon_ready_d = r_mon_ready;
    w_mon_error_d = r_mon_error;
    w_overrun_d   = r_overrun;
    w_brk_we_d    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_op_d        = i_cmd_jdo[37:36];
          w_brk_sel_d   = i_cmd_jdo[33:32];
          w_data_d      = i_cmd_jdo[31:0];
          w_cnt_d       = '0;
          w_mon_ready_d = 1'b0;
          w_mon_error_d = 1'b0;
          w_state_d     = StDone;
          if (i_cmd_jdo[34]) begin
            w_overrun_d = 1'b0;
          end
          unique case (i_cmd_ir)
            2'b00: begin
              if (i_cmd_jdo[37:36] == OpWrite || i_cmd_jdo[37:36] == OpRead) begin
                w_state_d = StMemReq;
              end else begin
                w_mon_ready_d = 1'b1;
                if (i_cmd_jdo[37:36] == OpSetAddr) begin
                  w_addr_d = i_cmd_jdo[ADDR_W-1:0];
                end
              end
            end
            2'b01: begin
              w_brk_we_d    = 1'b1;
              w_mon_ready_d = 1'b1;
            end
            default: w_mon_error_d = 1'b1;
          endcase
        end
      end
      StMemReq: begin
        // An ack arriving on the final timeout cycle still completes the access
        if (i_mem_ack) begin
          if (r_op == OpRead) begin
            w_rsp_data_d = i_mem_rdata;
          end
          if (AUTOINC) begin
            w_addr_d = r_addr + 1'b1;
          end
          w_mon_ready_d = 1'b1;
          w_state_d     = StDone;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_mon_error_d = 1'b1;
          w_state_d     = StDone;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (i_cmd_valid && r_state != StIdle) begin
      w_overrun_d = 1'b1;
    end
  end

  assign o_cmd_ready     = (r_state == StIdle);
  assign o_mem_req       = (r_state == StMemReq);
  assign o_mem_we        = o_mem_req && (r_op == OpWrite);
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_data;
  assign o_brk_we        = r_brk_we;
  assign o_brk_sel       = r_brk_sel;
  assign o_brk_wdata     = r_data;
  assign o_rsp_valid     = (r_state == StDone);
  assign o_rsp_data      = r_rsp_data;
  assign o_monitor_ready = r_mon_ready;
  assign o_monitor_error = r_mon_error;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed plus randomized bench for debug_cmd_sequencer against a per-command transaction model.
module tb_debug_cmd_sequencer;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [1:0]        cmd_ir;
  logic [37:0]       cmd_jdo;
  logic              cmd_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              brk_we;
  logic [1:0]        brk_sel;
  logic [31:0]       brk_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              monitor_ready;
  logic              monitor_error;
  logic              overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_rsp;
  logic              m_ovr;

  debug_cmd_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .AUTOINC(1'b1)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_cmd_valid    (cmd_valid),
    .i_cmd_ir       (cmd_ir),
    .i_cmd_jdo      (cmd_jdo),
    .o_cmd_ready    (cmd_ready),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .o_brk_we       (brk_we),
    .o_brk_sel      (brk_sel),
    .o_brk_wdata    (brk_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_monitor_ready(monitor_ready),
    .o_monitor_error(monitor_error),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic [1:0] op, input logic clr, input logic [1:0] sel,
                                     input logic [31:0] data);
    return {op, 1'b0, clr, sel, data};
  endfunction

  // Issues one command from IDLE (called at a negedge) and checks it through to the next IDLE.
  // ack_at: MEM_REQ cycle index carrying mem_ack (>= TIMEOUT means never acked).
  // poke: raise a dropped cmd_valid while busy.
  task automatic run_cmd(input logic [1:0] ir, input logic [37:0] jdo, input int ack_at,
                         input bit poke);
    logic [1:0]        op;
    bit                is_mem;
    bit                ok;
    logic [31:0]       rd;
    logic [ADDR_W-1:0] a_used;
    op     = jdo[37:36];
    is_mem = (ir == 2'b00) && op[1];
    rd     = '0;
    chk("idle_ready", cmd_ready, 1'b1);
    chk("overrun_pre", overrun, m_ovr);
    chk("rsp_data_pre", rsp_data, m_rsp);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_jdo   = jdo;
    if (jdo[34]) m_ovr = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ir    = 2'($urandom);
    cmd_jdo   = {6'($urandom), 32'($urandom)};
    if (is_mem) begin
      a_used = m_addr;
      for (int i = 0; i < TIMEOUT; i++) begin
        chk("mem_req", mem_req, 1'b1);
        chk("mem_we", mem_we, op == 2'b10);
        chk("mem_addr", mem_addr, a_used);
        chk("mem_wdata", mem_wdata, jdo[31:0]);
        chk("rsp_valid_busy", rsp_valid, 1'b0);
        chk("ready_busy", cmd_ready, 1'b0);
        if (poke && i == 0) begin
          cmd_valid = 1'b1;
          m_ovr     = 1'b1;
        end
        if (i == ack_at) begin
          rd        = $urandom;
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (i == ack_at) break;
      end
      ok = (ack_at < int'(TIMEOUT));
      if (ok) begin
        if (op == 2'b11) m_rsp = rd;
        m_addr = m_addr + 1'b1;
      end
    end else begin
      if (ir == 2'b00 && op == 2'b01) m_addr = jdo[ADDR_W-1:0];
      ok = (ir < 2'd2);
    end
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("mem_req_done", mem_req, 1'b0);
    chk("ready_done", cmd_ready, 1'b0);
    chk("mon_ready", monitor_ready, ok);
    chk("mon_error", monitor_error, !ok);
    chk("rsp_data", rsp_data, m_rsp);
    chk("brk_we", brk_we, ir == 2'b01);
    if (ir == 2'b01) begin
      chk("brk_sel", brk_sel, jdo[33:32]);
      chk("brk_wdata", brk_wdata, jdo[31:0]);
    end
    if (poke && !is_mem) begin
      cmd_valid = 1'b1;
      m_ovr     = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rsp_valid_after", rsp_valid, 1'b0);
    chk("brk_we_after", brk_we, 1'b0);
    chk("ready_after", cmd_ready, 1'b1);
    chk("overrun_after", overrun, m_ovr);
    chk("mon_ready_held", monitor_ready, ok);
  endtask

  initial begin
    logic [1:0]  r_ir;
    logic [37:0] r_jdo;
    int          r_sel;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ir    = '0;
    cmd_jdo   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    m_addr    = '0;
    m_rsp     = '0;
    m_ovr     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_brk_we", brk_we, 1'b0);
    chk("rst_brk_sel", brk_sel, '0);
    chk("rst_brk_wdata", brk_wdata, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_mon_ready", monitor_ready, 1'b0);
    chk("rst_mon_error", monitor_error, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Addressed write/read with auto-increment
    run_cmd(2'b00, mk(2'b01, 1'b0, 2'd0, 32'h0000_0010), 0, 1'b0);
    run_cmd(2'b00, mk(2'b10, 1'b0, 2'd0, 32'hCAFE_F00D), 1, 1'b0);
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 1, 1'b0);
    // Address wrap
    run_cmd(2'b00, mk(2'b01, 1'b0, 2'd0, 32'h0000_00FF), 0, 1'b0);
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 0, 1'b0);
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 2, 1'b0);
    // Ack on the last timeout cycle wins, then a full timeout
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), TIMEOUT - 1, 1'b0);
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 99, 1'b0);
    run_cmd(2'b00, mk(2'b10, 1'b0, 2'd0, 32'h1357_9BDF), 0, 1'b0);
    // Break write, illegal ir, NOP
    run_cmd(2'b01, mk(2'b00, 1'b0, 2'd2, 32'h0000_1234), 0, 1'b0);
    run_cmd(2'b11, mk(2'b11, 1'b0, 2'd1, 32'hDEAD_BEEF), 0, 1'b0);
    run_cmd(2'b10, mk(2'b10, 1'b0, 2'd3, 32'h0BAD_0BAD), 0, 1'b0);
    run_cmd(2'b00, mk(2'b00, 1'b0, 2'd0, 32'h0), 0, 1'b0);
    // Overrun during MEM_REQ and DONE, cleared by jdo[34]
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 3, 1'b1);
    run_cmd(2'b00, mk(2'b00, 1'b1, 2'd0, 32'h0), 0, 1'b0);
    run_cmd(2'b01, mk(2'b00, 1'b0, 2'd1, 32'h5555_AAAA), 0, 1'b1);
    run_cmd(2'b11, mk(2'b00, 1'b1, 2'd0, 32'h0), 0, 1'b0);

    // Reset in MEM_REQ cycle 3 followed by a stray ack
    cmd_valid = 1'b1;
    cmd_ir    = 2'b00;
    cmd_jdo   = mk(2'b11, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_ready", cmd_ready, 1'b1);
    chk("async_rst_rsp_data", rsp_data, '0);
    @(negedge clk);
    reset  = 1'b0;
    m_addr = '0;
    m_rsp  = '0;
    m_ovr  = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_rsp_valid", rsp_valid, 1'b0);
    chk("stray_mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk("stray_rsp_valid2", rsp_valid, 1'b0);
    chk("stray_mon_ready", monitor_ready, 1'b0);
    run_cmd(2'b00, mk(2'b11, 1'b0, 2'd0, 32'h0), 1, 1'b0);

    // Randomized commands
    for (int n = 0; n < 80; n++) begin
      r_sel = $urandom_range(0, 7);
      r_ir  = (r_sel < 4) ? 2'b00 : (r_sel < 6) ? 2'b01 : 2'($urandom_range(2, 3));
      r_jdo = {6'($urandom), 32'($urandom)};
      r_jdo[34] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_rsp_valid", rsp_valid, 1'b0);
        chk("idle_ack_mem_req", mem_req, 1'b0);
      end
      run_cmd(r_ir, r_jdo, $urandom_range(0, TIMEOUT + 4), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
